isolate_rightmost_1_bit_log2: RTL and testbench
===============================================

# isolate_rightmost_1_bit_log2

Pipelined bit-scan block for WORD_WIDTH-bit masks. It isolates the least-significant set bit of an input mask and converts that one-hot word into its zero-based bit index. It also flags the all-zero case. It sits in front of arbiters, event encoders and table-index logic that need one winner out of several simultaneous requests, with LSB having highest priority.

## Interface
Parameters:
- WORD_WIDTH, default 8: mask width; must be ≥ 2.

Ports:
- clock  input  1  single clock; all state on rising edge.
- reset_n  input  1  reset, asynchronous and active-low; one clock; reset is asynchronous and active-low.
- in_valid  input  1  word_in is valid this cycle.
- word_in  input  WORD_WIDTH  request bitmask.
- out_valid  output  1  outputs below carry a result.
- one_hot_out  output  WORD_WIDTH  word_in with all but the rightmost 1 cleared.
- index_out  output  WORD_WIDTH  zero-based index of the rightmost 1; upper bits beyond clog2(WORD_WIDTH) are zero.
- index_valid  output  1  1 when word_in was non-zero; 0 means index_out is 0 but meaningless.

## Operation
- Isolation: lsb = word_in & (~word_in + 1), computed in WORD_WIDTH-bit two's-complement with wrap. Zero in gives zero out.
- Logarithm of the one-hot word:
  - Bit k of index_out is the OR of all one_hot bits whose position has bit k set.
  - For one-hot input this gives the exact log2.
  - For all-zero input it gives 0.
- index_valid = (one_hot ≠ 0), i.e. the logarithm is defined.
- Examples at WORD_WIDTH=8:
  - 0x1F → one-hot 0x01, index 0.
  - 0x0C → one-hot 0x04, index 2.
  - 0x80 → one-hot 0x80, index 7.
- No handshake back-pressure: the block accepts a word every cycle.
- in_valid only travels with the data. Data registers load every cycle regardless of in_valid.

## Timing
- Two-stage pipeline, latency 2 cycles, throughput 1 word per cycle.
- Stage 1 registers one_hot and valid.
- Stage 2 registers one_hot_out, index_out, index_valid and out_valid.
- Input sampled at edge N appears on the outputs after edge N+1, and is visible during cycle N+2.
- Reset values, applied asynchronously when reset_n falls and held while it is low:
  - out_valid = 0, one_hot_out = 0, index_out = 0, index_valid = 0.
  - All stage-1 registers = 0.
- Reset release: the first word sampled on the first rising edge with reset_n high emerges 2 cycles later. No spurious out_valid occurs before that.
- Reset mid-stream: all in-flight words are discarded. out_valid drops to 0 immediately, without waiting for a clock edge.
- Back-to-back words: each word produces its own result on consecutive cycles, with no bubbles.
- Zero word with in_valid=1: out_valid=1, index_valid=0, index_out=0, one_hot_out=0.

## Structure
- Shared package holds:
  - the index width constant computed with clog2(WORD_WIDTH);
  - a function to zero-extend an index to WORD_WIDTH.
- Two combinational sub-modules, instantiated in stage 1 and stage 2 respectively:
  - bitmask_isolate_rightmost_1_bit (word_in → word_out).
  - logarithm_of_powers_of_two (one_hot_in → logarithm_out, logarithm_undefined). logarithm_undefined = 1 when the input is zero.
- The top level contains only the two pipeline register stages and the inversion of logarithm_undefined into index_valid.

## Test plan
- Priority sweep, WORD_WIDTH=8: send 0x1F, 0x02, 0x0C, 0x18, 0x10, 0x80 back-to-back with in_valid=1.
  - Required, 2 cycles later on consecutive cycles: one-hot 0x01/0x02/0x04/0x08/0x10/0x80 with index 0/1/2/3/4/7, index_valid=1.
- Zero input: 0x00 with in_valid=1 → out_valid=1, index_valid=0, index_out=0, one_hot_out=0.
- Exhaustive check: all 256 values at WORD_WIDTH=8.
  - one_hot_out must match a reference word & -word.
  - index_out must match the reference position of the lowest set bit.
- in_valid gaps: alternate in_valid 1/0 → out_valid reproduces the same pattern delayed by exactly 2 cycles.
- Async reset mid-stream: assert reset_n=0 between clock edges while out_valid=1.
  - All outputs go to 0 before the next edge.
  - After release, the first output appears exactly 2 cycles after the first sampled word.
- Width corners: WORD_WIDTH=2 and WORD_WIDTH=17.
  - MSB-only input → index 1 and 16 respectively.
  - All-ones input → index 0.

Source files
------------

// File: rtl/isolate_rightmost_1_bit_log2_pkg.sv
// isolate_rightmost_1_bit_log2_pkg: shared index-width constant and index zero-extension helper
package isolate_rightmost_1_bit_log2_pkg;
  localparam int MAX_WORD_WIDTH = 64;
  localparam int DEFAULT_WORD_WIDTH = 8;
  localparam int DEFAULT_INDEX_WIDTH = $clog2(DEFAULT_WORD_WIDTH);
  function automatic int index_width(input int word_width);
    return (word_width < 2) ? 1 : $clog2(word_width);
  endfunction
  function automatic logic [MAX_WORD_WIDTH-1:0] zero_extend_index(input logic [MAX_WORD_WIDTH-1:0] index, input int width);
    return index & ((MAX_WORD_WIDTH'(1) << width) - MAX_WORD_WIDTH'(1));
  endfunction
endpackage

// File: rtl/bitmask_isolate_rightmost_1_bit.sv
// bitmask_isolate_rightmost_1_bit: keeps only the least-significant set bit of a mask
module bitmask_isolate_rightmost_1_bit #(
  parameter int WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0] word_in,
  output logic [WORD_WIDTH-1:0] word_out
);
  assign word_out = word_in & (~word_in + WORD_WIDTH'(1));
endmodule

// File: rtl/logarithm_of_powers_of_two.sv
// logarithm_of_powers_of_two: log2 of a one-hot word, flagging the undefined all-zero case
module logarithm_of_powers_of_two
  import isolate_rightmost_1_bit_log2_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int INDEX_WIDTH = index_width(WORD_WIDTH)
) (
  input  logic [WORD_WIDTH-1:0]  one_hot_in,
  output logic [INDEX_WIDTH-1:0] logarithm_out,
  output logic                   logarithm_undefined
);
  always_comb begin
    logarithm_out = '0;
    for (int p = 0; p < WORD_WIDTH; p++)
      logarithm_out = logarithm_out | (one_hot_in[p] ? INDEX_WIDTH'(p) : '0);
  end
  assign logarithm_undefined = ~|one_hot_in;
endmodule

// File: rtl/isolate_rightmost_1_bit_log2.sv
// isolate_rightmost_1_bit_log2: two-stage pipeline isolating the lowest set bit and encoding its index
module isolate_rightmost_1_bit_log2
  import isolate_rightmost_1_bit_log2_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [WORD_WIDTH-1:0] word_in,
  output logic                  out_valid,
  output logic [WORD_WIDTH-1:0] one_hot_out,
  output logic [WORD_WIDTH-1:0] index_out,
  output logic                  index_valid
);
  localparam int IW = index_width(WORD_WIDTH);
  logic [WORD_WIDTH-1:0] lsb;
  logic [WORD_WIDTH-1:0] s1_one_hot;
  logic                  s1_valid;
  logic [IW-1:0]         log_index;
  logic                  log_undefined;
  bitmask_isolate_rightmost_1_bit #(.WORD_WIDTH(WORD_WIDTH)) u_isolate (
    .word_in (word_in),
    .word_out(lsb)
  );
  logarithm_of_powers_of_two #(.WORD_WIDTH(WORD_WIDTH), .INDEX_WIDTH(IW)) u_log (
    .one_hot_in         (s1_one_hot),
    .logarithm_out      (log_index),
    .logarithm_undefined(log_undefined)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_one_hot  <= '0;
      s1_valid    <= 1'b0;
      one_hot_out <= '0;
      index_out   <= '0;
      index_valid <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      s1_one_hot  <= lsb;
      s1_valid    <= in_valid;
      one_hot_out <= s1_one_hot;
      index_out   <= WORD_WIDTH'(zero_extend_index(MAX_WORD_WIDTH'(log_index), IW));
      index_valid <= ~log_undefined;
      out_valid   <= s1_valid;
    end
  end
endmodule

// File: tb/tb_isolate_rightmost_1_bit_log2.sv
// tb_isolate_rightmost_1_bit_log2: scoreboard bench over widths 8, 2 and 17 against a lowest-set-bit model
module tb_isolate_rightmost_1_bit_log2;
  typedef struct {
    logic [16:0] oh;
    logic [16:0] idx;
    logic        iv;
    int          cyc;
  } exp_t;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  w8 = '0;
  logic [1:0]  w2 = '0;
  logic [16:0] w17 = '0;
  logic        ov8, iv8, ov2, iv2, ov17, iv17;
  logic [7:0]  oh8, ix8;
  logic [1:0]  oh2, ix2;
  logic [16:0] oh17, ix17;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          done = 1'b0;
  exp_t        q8[$];
  exp_t        q2[$];
  exp_t        q17[$];
  logic [16:0] sweep [6] = '{17'h1F, 17'h02, 17'h0C, 17'h18, 17'h10, 17'h80};

  isolate_rightmost_1_bit_log2 #(.WORD_WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .word_in(w8),
    .out_valid(ov8), .one_hot_out(oh8), .index_out(ix8), .index_valid(iv8));
  isolate_rightmost_1_bit_log2 #(.WORD_WIDTH(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .word_in(w2),
    .out_valid(ov2), .one_hot_out(oh2), .index_out(ix2), .index_valid(iv2));
  isolate_rightmost_1_bit_log2 #(.WORD_WIDTH(17)) dut17 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .word_in(w17),
    .out_valid(ov17), .one_hot_out(oh17), .index_out(ix17), .index_valid(iv17));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Lowest set bit found by scanning downward so the smallest position wins.
  function automatic exp_t model(input logic [16:0] w, input int width, input int issue);
    exp_t e;
    e.oh = '0;
    e.idx = '0;
    e.iv = 1'b0;
    e.cyc = issue + 2;
    for (int i = width - 1; i >= 0; i--)
      if (w[i]) begin
        e.oh = 17'(1) << i;
        e.idx = 17'(i);
        e.iv = 1'b1;
      end
    return e;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [16:0] oh, input logic [16:0] idx, input logic iv);
    chk({tag, "_one_hot"}, int'(oh), int'(e.oh));
    chk({tag, "_index"}, int'(idx), int'(e.idx));
    chk({tag, "_index_valid"}, int'(iv), int'(e.iv));
    chk({tag, "_latency_cycle"}, cyc, e.cyc);
  endtask

  task automatic send(input logic v, input logic [16:0] w);
    @(posedge clock);
    #1;
    in_valid = v;
    w8 = w[7:0];
    w2 = w[1:0];
    w17 = w;
    if (v) begin
      q8.push_back(model(w, 8, cyc));
      q2.push_back(model(w, 2, cyc));
      q17.push_back(model(w, 17, cyc));
    end
  endtask

  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      #1;
      q8.delete();
      q2.delete();
      q17.delete();
      chk("rst_out_valid8", int'(ov8), 0);
      chk("rst_one_hot8", int'(oh8), 0);
      chk("rst_index8", int'(ix8), 0);
      chk("rst_index_valid8", int'(iv8), 0);
      chk("rst_out_valid2", int'(ov2), 0);
      chk("rst_out_valid17", int'(ov17), 0);
      chk("rst_index17", int'(ix17), 0);
    end else if (done) begin
      chk("q8_drained", q8.size(), 0);
      chk("q2_drained", q2.size(), 0);
      chk("q17_drained", q17.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end else begin
      if (ov8) begin
        if (q8.size() == 0) chk("spurious_out_valid8", 1, 0);
        else cmp("w8", q8.pop_front(), 17'(oh8), 17'(ix8), iv8);
      end
      if (ov2) begin
        if (q2.size() == 0) chk("spurious_out_valid2", 1, 0);
        else cmp("w2", q2.pop_front(), 17'(oh2), 17'(ix2), iv2);
      end
      if (ov17) begin
        if (q17.size() == 0) chk("spurious_out_valid17", 1, 0);
        else cmp("w17", q17.pop_front(), oh17, ix17, iv17);
      end
    end
  end

  initial begin
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #2 reset_n = 1'b1;
    foreach (sweep[i]) send(1'b1, sweep[i]);
    send(1'b1, 17'h0);
    for (int i = 0; i < 256; i++) send(1'b1, {9'($urandom), 8'(i)});
    for (int i = 0; i < 20; i++) send(i % 2 == 0, 17'($urandom));
    send(1'b1, 17'h10000);
    send(1'b1, 17'h00002);
    send(1'b1, 17'h1FFFF);
    send(1'b1, 17'h00001);
    for (int i = 0; i < 30; i++) send(1'($urandom), 17'($urandom));
    for (int i = 0; i < 4; i++) send(1'b1, 17'($urandom));
    @(negedge clock);
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2;
    reset_n = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) send(1'b1, 17'($urandom));
    repeat (4) send(1'b0, 17'h0);
    done = 1'b1;
    repeat (5) @(posedge clock);
    $display("FAIL timeout: monitor did not reach summary");
    $fatal(1);
  end
endmodule
